// File: rtl/disp_arbiter_pkg.sv
// Shared display definitions: arbiter state encoding, source count and the
// idle word/point values shown when no source owns the display.
package disp_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam int          NUM_SRC  = 4;
  localparam logic [15:0] IDLE_DAT = 16'h0000;
  localparam logic [1:0]  IDLE_SW  = 2'b01;

  function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_SRC-1:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request searched from last+1
// upward modulo 4, so the previous winner is always considered last.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_base;
  logic [3:0] w_rot;
  logic [1:0] w_off;

  // Rotate requests so bit 0 is the highest-priority source, then priority-encode.
  always_comb begin
    w_base  = i_last + 2'd1;
    w_off   = 2'd0;
    o_valid = 1'b1;
    case (w_base)
      2'd0:    w_rot = i_req;
      2'd1:    w_rot = {i_req[0], i_req[3:1]};
      2'd2:    w_rot = {i_req[1:0], i_req[3:2]};
      2'd3:    w_rot = {i_req[2:0], i_req[3]};
      default: w_rot = i_req;
    endcase
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: begin
        w_off   = 2'd0;
        o_valid = 1'b0;
      end
    endcase
    o_idx = w_base + w_off;
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 4-digit display driver: grants one source at a time
// for HOLD_MS ce1ms pulses and forwards its live hex word and point select.
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int HOLD_MS = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce1ms,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  req_dat,
  input  logic [2*NUM_SRC-1:0]   req_pnt,
  output logic [15:0]            dat,
  output logic [1:0]             SW,
  output logic [NUM_SRC-1:0]     gnt,
  output logic                   busy
);

  localparam logic [15:0] L_TERM = 16'(HOLD_MS - 1);

  state_t      r_state;
  logic [1:0]  r_last;
  logic [15:0] r_cnt;

  logic [1:0]  w_win;
  logic        w_win_vld;
  logic [15:0] w_win_dat;
  logic [1:0]  w_win_pnt;
  logic [15:0] w_hold_dat;
  logic [1:0]  w_hold_pnt;
  logic        w_hold_req;
  logic        w_expire;
  logic        w_rearb;

  // r_last doubles as the current holder while in SHOW, so one picker serves
  // both the idle grant and re-arbitration with the holder searched last.
  rr_pick4 u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  // Source data muxes and the re-arbitration trigger.
  always_comb begin
    w_win_dat  = req_dat[{w_win, 4'b0000} +: 16];
    w_win_pnt  = req_pnt[{w_win, 1'b0} +: 2];
    w_hold_dat = req_dat[{r_last, 4'b0000} +: 16];
    w_hold_pnt = req_pnt[{r_last, 1'b0} +: 2];
    w_hold_req = req[r_last];
    w_expire   = ce1ms & (r_cnt == L_TERM);
    w_rearb    = ~w_hold_req | w_expire;
  end

  // Arbitration FSM, hold counter and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_cnt   <= 16'd0;
      gnt     <= 4'b0000;
      dat     <= IDLE_DAT;
      SW      <= IDLE_SW;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_state <= ST_SHOW;
            r_last  <= w_win;
            r_cnt   <= 16'd0;
            gnt     <= onehot4(w_win);
            dat     <= w_win_dat;
            SW      <= w_win_pnt;
            busy    <= 1'b1;
          end else begin
            gnt  <= 4'b0000;
            dat  <= IDLE_DAT;
            SW   <= IDLE_SW;
            busy <= 1'b0;
          end
        end
        ST_SHOW: begin
          // Expiry and holder drop collapse into a single re-arbitration here.
          if (w_rearb) begin
            if (w_win_vld) begin
              r_last <= w_win;
              r_cnt  <= 16'd0;
              gnt    <= onehot4(w_win);
              dat    <= w_win_dat;
              SW     <= w_win_pnt;
              busy   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= 16'd0;
              gnt     <= 4'b0000;
              dat     <= IDLE_DAT;
              SW      <= IDLE_SW;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + {15'd0, ce1ms};
            dat   <= w_hold_dat;
            SW    <= w_hold_pnt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'd0;
          gnt     <= 4'b0000;
          dat     <= IDLE_DAT;
          SW      <= IDLE_SW;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD_MS=3 and ce1ms every 10 cycles.
module tb_disp_arbiter;

  localparam logic [63:0] DA = 64'h3C3C_A5C3_1234_0A0A;
  localparam logic [63:0] DB = 64'h3C3C_A5C3_4321_0A0A;
  localparam logic [7:0]  PP = 8'hE4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce1ms;
  logic [3:0]  req;
  logic [63:0] req_dat;
  logic [7:0]  req_pnt;
  logic [15:0] dat;
  logic [1:0]  SW;
  logic [3:0]  gnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] rdat;
    logic [7:0]  rpnt;
    int          ncyc;
    logic [3:0]  e_gnt;
    logic [15:0] e_dat;
    logic [1:0]  e_sw;
    logic        e_busy;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  disp_arbiter #(.HOLD_MS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce1ms   (ce1ms),
    .req     (req),
    .req_dat (req_dat),
    .req_pnt (req_pnt),
    .dat     (dat),
    .SW      (SW),
    .gnt     (gnt),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [15:0] d,
                         input logic [1:0] s, input logic b);
    chk({tag, " gnt"},  64'(gnt),  64'(g));
    chk({tag, " dat"},  64'(dat),  64'(d));
    chk({tag, " SW"},   64'(SW),   64'(s));
    chk({tag, " busy"}, 64'(busy), 64'(b));
  endtask

  // Advance n clock edges; ce1ms is high on every tenth edge counted from phase.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      ce1ms = (phase == 9);
      @(posedge clk);
      phase = (phase + 1) % 10;
      @(negedge clk);
      ce1ms = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    ce1ms   = 1'b0;
    req     = 4'b0000;
    req_dat = 64'h0;
    req_pnt = 8'h00;

    // Reset values, then idle with no requests.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("reset", 4'b0000, 16'h0000, 2'b01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    req_dat = DA;
    req_pnt = PP;
    tick(3);
    chk_out("idle_after_reset", 4'b0000, 16'h0000, 2'b01, 1'b0);

    // Rotation 0->1->3->0, mid-grant data change, then single source retention.
    vecs[0]  = '{4'b1011, DA, PP,  1, 4'b0001, 16'h0A0A, 2'b00, 1'b1};
    vecs[1]  = '{4'b1011, DA, PP, 28, 4'b0001, 16'h0A0A, 2'b00, 1'b1};
    vecs[2]  = '{4'b1011, DA, PP,  1, 4'b0010, 16'h1234, 2'b01, 1'b1};
    vecs[3]  = '{4'b1011, DA, PP, 15, 4'b0010, 16'h1234, 2'b01, 1'b1};
    vecs[4]  = '{4'b1011, DB, PP,  1, 4'b0010, 16'h4321, 2'b01, 1'b1};
    vecs[5]  = '{4'b1011, DB, PP, 13, 4'b0010, 16'h4321, 2'b01, 1'b1};
    vecs[6]  = '{4'b1011, DB, PP,  1, 4'b1000, 16'h3C3C, 2'b11, 1'b1};
    vecs[7]  = '{4'b1011, DB, PP, 29, 4'b1000, 16'h3C3C, 2'b11, 1'b1};
    vecs[8]  = '{4'b1011, DB, PP,  1, 4'b0001, 16'h0A0A, 2'b00, 1'b1};
    vecs[9]  = '{4'b0000, DB, PP,  1, 4'b0000, 16'h0000, 2'b01, 1'b0};
    vecs[10] = '{4'b0100, DB, PP,  1, 4'b0100, 16'hA5C3, 2'b10, 1'b1};
    vecs[11] = '{4'b0100, DB, PP, 28, 4'b0100, 16'hA5C3, 2'b10, 1'b1};
    vecs[12] = '{4'b0100, DB, PP, 10, 4'b0100, 16'hA5C3, 2'b10, 1'b1};
    vecs[13] = '{4'b0000, DB, PP,  1, 4'b0000, 16'h0000, 2'b01, 1'b0};

    phase = 0;
    for (int i = 0; i < 14; i++) begin
      req     = vecs[i].req;
      req_dat = vecs[i].rdat;
      req_pnt = vecs[i].rpnt;
      tick(vecs[i].ncyc);
      chk_out($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_dat, vecs[i].e_sw, vecs[i].e_busy);
    end

    // Early release: source 1 drops after one pulse while source 3 waits.
    phase = 0;
    req = 4'b0010;
    tick(1);
    chk_out("er_grant1", 4'b0010, 16'h4321, 2'b01, 1'b1);
    req = 4'b1010;
    tick(11);
    chk_out("er_nopreempt", 4'b0010, 16'h4321, 2'b01, 1'b1);
    req = 4'b1000;
    tick(1);
    chk_out("er_switch3", 4'b1000, 16'h3C3C, 2'b11, 1'b1);
    req = 4'b0000;
    tick(1);
    chk_out("er_idle", 4'b0000, 16'h0000, 2'b01, 1'b0);

    // Fairness on expiry, then expiry coinciding with holder drop.
    phase = 0;
    req = 4'b0001;
    tick(15);
    chk_out("fair_hold0", 4'b0001, 16'h0A0A, 2'b00, 1'b1);
    req = 4'b0011;
    tick(14);
    chk_out("fair_nopreempt", 4'b0001, 16'h0A0A, 2'b00, 1'b1);
    tick(1);
    chk_out("fair_terminal", 4'b0010, 16'h4321, 2'b01, 1'b1);
    tick(29);
    chk_out("fair_hold1", 4'b0010, 16'h4321, 2'b01, 1'b1);
    req = 4'b0001;
    tick(1);
    chk_out("simul_expire_drop", 4'b0001, 16'h0A0A, 2'b00, 1'b1);
    tick(20);
    chk_out("simul_after", 4'b0001, 16'h0A0A, 2'b00, 1'b1);

    // Asynchronous reset during a source 3 grant, restart from source 0.
    req = 4'b1000;
    tick(1);
    chk_out("rst_pre_src3", 4'b1000, 16'h3C3C, 2'b11, 1'b1);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 4'b0000, 16'h0000, 2'b01, 1'b0);
    @(negedge clk);
    req   = 4'b1111;
    rst_n = 1'b1;
    tick(1);
    chk_out("rst_restart0", 4'b0001, 16'h0A0A, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
